// File: rtl/harness_mul_rr_arbiter_if.sv
// Bundle of requester, shared-multiplier and response signals for the
// round-robin multiplier arbiter. The arbiter uses the slave view; the
// harness side (requesters, multiplier, response sink) uses the master view.
interface harness_mul_rr_arbiter_if #(
   parameter int NUM_REQ  = 4,
   parameter int A_WIDTH  = 8,
   parameter int B_WIDTH  = 7,
   parameter int P_WIDTH  = 15,
   parameter int ID_WIDTH = 2
);
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ-1:0]         req_ready;
   logic [NUM_REQ*A_WIDTH-1:0] req_a;
   logic [NUM_REQ*B_WIDTH-1:0] req_b;
   logic [A_WIDTH-1:0]         mul_din0;
   logic [B_WIDTH-1:0]         mul_din1;
   logic [P_WIDTH-1:0]         mul_dout;
   logic                       rsp_valid;
   logic                       rsp_ready;
   logic [P_WIDTH-1:0]         rsp_data;
   logic [ID_WIDTH-1:0]        rsp_id;

   modport slave (
      input  req_valid, req_a, req_b, mul_dout, rsp_ready,
      output req_ready, mul_din0, mul_din1, rsp_valid, rsp_data, rsp_id
   );

   modport master (
      output req_valid, req_a, req_b, mul_dout, rsp_ready,
      input  req_ready, mul_din0, mul_din1, rsp_valid, rsp_data, rsp_id
   );
endinterface

// File: rtl/harness_mul_rr_arbiter.sv
// Round-robin arbiter sharing one combinational multiplier among NUM_REQ
// requesters. The winning requester's operands are steered to the shared
// multiplier and its product is captured in a one-entry output register
// tagged with the requester index.
//
// state    | meaning
// ---------+---------------------------------------------
// ST_EMPTY | output register empty, rsp_valid=0
// ST_FULL  | output register holds a product, rsp_valid=1
module harness_mul_rr_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int A_WIDTH  = 8,
   parameter int B_WIDTH  = 7,
   parameter int P_WIDTH  = 15,
   parameter int ID_WIDTH = 2
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst_n,
   harness_mul_rr_arbiter_if.slave   bus
);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]          r_state;
   logic [P_WIDTH-1:0]  r_data;
   logic [ID_WIDTH-1:0] r_id;
   logic [ID_WIDTH-1:0] r_ptr;

   logic [NUM_REQ-1:0]  w_grant;
   logic [ID_WIDTH-1:0] w_gidx;
   logic                w_found;
   logic                w_can_accept;
   logic                w_accept;
   logic [ID_WIDTH-1:0] w_ptr_next;

   function automatic logic [ID_WIDTH-1:0] f_wrap(input int unsigned v);
      return ID_WIDTH'(v % NUM_REQ);
   endfunction

   // Round-robin search starting at r_ptr, wrapping at NUM_REQ-1
   always_comb begin
      w_grant = '0;
      w_gidx  = '0;
      w_found = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!w_found && bus.req_valid[f_wrap(32'(r_ptr) + k)]) begin
            w_gidx                          = f_wrap(32'(r_ptr) + k);
            w_grant[f_wrap(32'(r_ptr) + k)] = 1'b1;
            w_found                         = 1'b1;
         end
      end
   end

   // Drain of the output register frees it in the same cycle, so a
   // continuously drained stream has no bubbles. Reset masks all accepts.
   assign w_can_accept  = (r_state == ST_EMPTY) | bus.rsp_ready;
   assign bus.req_ready = w_grant & {NUM_REQ{w_can_accept & ap_rst_n}};
   assign w_accept      = |(bus.req_valid & bus.req_ready);
   assign w_ptr_next    = (w_gidx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;

   // Operands follow the grant even while the output register is stalled
   assign bus.mul_din0 = w_found ? bus.req_a[int'(w_gidx)*A_WIDTH +: A_WIDTH] : '0;
   assign bus.mul_din1 = w_found ? bus.req_b[int'(w_gidx)*B_WIDTH +: B_WIDTH] : '0;

   assign bus.rsp_valid = (r_state == ST_FULL);
   assign bus.rsp_data  = r_data;
   assign bus.rsp_id    = r_id;

   // Output register FSM, product capture and round-robin pointer update
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         r_state <= ST_EMPTY;
         r_data  <= '0;
         r_id    <= '0;
         r_ptr   <= '0;
      end else if (w_accept) begin
         r_state <= ST_FULL;
         r_data  <= bus.mul_dout;
         r_id    <= w_gidx;
         r_ptr   <= w_ptr_next;
      end else if (bus.rsp_ready) begin
         r_state <= ST_EMPTY;
      end
   end

endmodule

// File: tb/tb_harness_mul_rr_arbiter.sv
// Directed bench for the round-robin multiplier arbiter. The shared
// multiplier is modelled here as harness logic; expected products are
// hand-computed constants.
module tb_harness_mul_rr_arbiter;

   logic ap_clk;
   logic ap_rst_n;
   int   checks;
   int   errors;

   harness_mul_rr_arbiter_if #(.NUM_REQ(4), .A_WIDTH(8), .B_WIDTH(7),
                               .P_WIDTH(15), .ID_WIDTH(2)) bus ();

   harness_mul_rr_arbiter #(.NUM_REQ(4), .A_WIDTH(8), .B_WIDTH(7),
                            .P_WIDTH(15), .ID_WIDTH(2)) dut (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .bus      (bus.slave)
   );

   // shared combinational multiplier: unsigned 8b x signed 7b -> 15b
   assign bus.mul_dout = $signed({7'b0, bus.mul_din0}) *
                         $signed({{8{bus.mul_din1[6]}}, bus.mul_din1});

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   task automatic set_req(input int i, input logic [7:0] a, input logic [6:0] b);
      bus.req_a[i*8 +: 8] = a;
      bus.req_b[i*7 +: 7] = b;
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic to_neg();
      @(negedge ap_clk);
   endtask

   task automatic default_ops();
      set_req(0, 8'd10,  7'd3);    // 30     -> 15'h001E
      set_req(1, 8'd200, 7'h7B);   // -1000  -> 15'h7C18
      set_req(2, 8'd7,   7'h7F);   // -7     -> 15'h7FF9
      set_req(3, 8'd100, 7'd50);   // 5000   -> 15'h1388
   endtask

   task automatic drain();
      to_neg();
      bus.req_valid = 4'b0000;
      bus.rsp_ready = 1'b1;
      tick();
      to_neg();
   endtask

   task automatic test_reset();
      to_neg();
      ap_rst_n      = 1'b0;
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 1'b1;
      default_ops();
      tick();
      tick();
      checks++;
      if (bus.req_ready !== 4'b0000) begin
         errors++; $display("FAIL reset_req_ready got %b want 0000", bus.req_ready);
      end
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 15'h0 || bus.rsp_id !== 2'd0) begin
         errors++; $display("FAIL reset_outputs got v=%b d=%h id=%0d want v=0 d=0000 id=0",
                            bus.rsp_valid, bus.rsp_data, bus.rsp_id);
      end
      to_neg();
      ap_rst_n = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) begin
         errors++; $display("FAIL reset_first_grant got %b want 0001", bus.req_ready);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 15'h001E) begin
         errors++; $display("FAIL reset_first_rsp got v=%b d=%h id=%0d want v=1 d=001e id=0",
                            bus.rsp_valid, bus.rsp_data, bus.rsp_id);
      end
      drain();
   endtask

   task automatic test_single();
      bus.req_valid = 4'b0100;
      set_req(2, 8'd255, 7'h40);
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 15'h4040 || bus.rsp_id !== 2'd2) begin
         errors++; $display("FAIL single_neg got v=%b d=%h id=%0d want v=1 d=4040 id=2",
                            bus.rsp_valid, bus.rsp_data, bus.rsp_id);
      end
      drain();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         errors++; $display("FAIL single_drain got v=%b want 0", bus.rsp_valid);
      end
      bus.req_valid = 4'b0100;
      set_req(2, 8'd255, 7'h3F);
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 15'h3EC1 || bus.rsp_id !== 2'd2) begin
         errors++; $display("FAIL single_pos got v=%b d=%h id=%0d want v=1 d=3ec1 id=2",
                            bus.rsp_valid, bus.rsp_data, bus.rsp_id);
      end
      drain();
   endtask

   task automatic test_round_robin();
      logic [14:0] exp_p [4];
      logic [3:0]  exp_g;
      exp_p[0] = 15'h001E;
      exp_p[1] = 15'h7C18;
      exp_p[2] = 15'h7FF9;
      exp_p[3] = 15'h1388;
      ap_rst_n = 1'b0;
      tick();
      to_neg();
      ap_rst_n = 1'b1;
      default_ops();
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         exp_g = 4'b0001 << (k % 4);
         checks++;
         if (bus.req_ready !== exp_g) begin
            errors++; $display("FAIL rr_grant[%0d] got %b want %b", k, bus.req_ready, exp_g);
         end
         tick();
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(k % 4) || bus.rsp_data !== exp_p[k % 4]) begin
            errors++; $display("FAIL rr_rsp[%0d] got v=%b d=%h id=%0d want v=1 d=%h id=%0d",
                               k, bus.rsp_valid, bus.rsp_data, bus.rsp_id, exp_p[k % 4], k % 4);
         end
         to_neg();
      end
   endtask

   task automatic test_backpressure();
      // register holds id 3 / 5000, pointer back at 0
      bus.rsp_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (bus.req_ready !== 4'b0000 || bus.mul_din0 !== 8'd10 || bus.mul_din1 !== 7'd3) begin
            errors++; $display("FAIL bp_stall_comb[%0d] got rdy=%b d0=%0d d1=%0d want rdy=0000 d0=10 d1=3",
                               k, bus.req_ready, bus.mul_din0, bus.mul_din1);
         end
         tick();
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3 || bus.rsp_data !== 15'h1388) begin
            errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h id=%0d want v=1 d=1388 id=3",
                               k, bus.rsp_valid, bus.rsp_data, bus.rsp_id);
         end
         to_neg();
      end
      bus.rsp_ready = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) begin
         errors++; $display("FAIL bp_release_grant got %b want 0001", bus.req_ready);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 15'h001E) begin
         errors++; $display("FAIL bp_release_rsp got v=%b d=%h id=%0d want v=1 d=001e id=0",
                            bus.rsp_valid, bus.rsp_data, bus.rsp_id);
      end
      drain();
   endtask

   task automatic test_skip_wrap();
      bus.req_valid = 4'b0100;      // accept req 2 -> pointer 3
      tick();
      to_neg();
      bus.req_valid = 4'b0010;
      set_req(1, 8'd3, 7'h7E);
      #1;
      checks++;
      if (bus.req_ready !== 4'b0010) begin
         errors++; $display("FAIL wrap_grant got %b want 0010", bus.req_ready);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_data !== 15'h7FFA) begin
         errors++; $display("FAIL wrap_rsp got v=%b d=%h id=%0d want v=1 d=7ffa id=1",
                            bus.rsp_valid, bus.rsp_data, bus.rsp_id);
      end
      to_neg();
      bus.req_valid = 4'b0110;      // pointer 2 -> req 2 wins over req 1
      #1;
      checks++;
      if (bus.req_ready !== 4'b0100) begin
         errors++; $display("FAIL wrap_ptr_grant got %b want 0100", bus.req_ready);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      default_ops();
      bus.req_valid = 4'b0010;      // accept req 1 -> pointer 2
      tick();
      to_neg();
      bus.req_valid = 4'b0000;
      bus.rsp_ready = 1'b0;
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_data !== 15'h7C18) begin
         errors++; $display("FAIL mid_full got v=%b d=%h id=%0d want v=1 d=7c18 id=1",
                            bus.rsp_valid, bus.rsp_data, bus.rsp_id);
      end
      to_neg();
      ap_rst_n = 1'b0;
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 15'h0) begin
         errors++; $display("FAIL mid_reset got v=%b d=%h id=%0d want v=0 d=0000 id=0",
                            bus.rsp_valid, bus.rsp_data, bus.rsp_id);
      end
      to_neg();
      ap_rst_n      = 1'b1;
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) begin
         errors++; $display("FAIL mid_ptr_reset got %b want 0001", bus.req_ready);
      end
      drain();
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      ap_rst_n      = 1'b0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_skip_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end

endmodule
